// File: rtl/debounce_pulse_pkg.sv
// Shared definitions for the debounce / edge-pulse stage.
// State encodings, counter sizing helpers and parameter sanity check.
package debounce_pulse_pkg;

  typedef enum logic [1:0] {
    IDLE_LOW   = 2'b00,
    CHECK_HIGH = 2'b01,
    IDLE_HIGH  = 2'b11,
    CHECK_LOW  = 2'b10
  } state_t;

  function automatic int cnt_w(int n);
    return (n < 1) ? 1 : $clog2(n + 1);
  endfunction

  function automatic int max2(int a, int b);
    return (a > b) ? a : b;
  endfunction

  // Terminal compare value: counters hit one sample before the event edge.
  function automatic int term_of(int n);
    return (n < 1) ? 0 : n - 1;
  endfunction

  function automatic bit cfg_ok(int dc, int rd, int rp);
    return (dc >= 2) && ((rd == 0) || (rp >= 1));
  endfunction

endpackage

// File: rtl/debounce_pulse_tick_counter.sv
// Saturating up-counter with sync clear, enable
// and a terminal-value compare flag.
module tick_counter #(
  parameter int W = 2
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         clr,
  input  logic         en,
  input  logic [W-1:0] term,
  output logic         hit
);

  logic [W-1:0] cnt_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt_q <= '0;
    end else if (clr) begin
      cnt_q <= '0;
    end else if (en && (cnt_q != {W{1'b1}})) begin
      cnt_q <= cnt_q + 1'b1;
    end
  end

  assign hit = (cnt_q == term);

endmodule

// File: rtl/debounce_pulse.sv
// Debounce of the synchronized button level with registered
// press / release pulses and optional auto-repeat while held.
module debounce_pulse
  import debounce_pulse_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 4,
  parameter int REPEAT_DELAY    = 0,
  parameter int REPEAT_PERIOD   = 1
) (
  input  logic clk,
  input  logic reset,
  input  logic dato_sync,
  output logic level,
  output logic rise_pulse,
  output logic fall_pulse,
  output logic rep_pulse
);

  localparam int SW = cnt_w(DEBOUNCE_CYCLES);
  localparam int RW =
    cnt_w(max2(REPEAT_DELAY, REPEAT_PERIOD));
  localparam bit REP_ON = (REPEAT_DELAY != 0);
  localparam bit CFG_OK =
    cfg_ok(DEBOUNCE_CYCLES, REPEAT_DELAY, REPEAT_PERIOD);

  localparam logic [SW-1:0] STAB_T =
    SW'(term_of(DEBOUNCE_CYCLES));
  localparam logic [RW-1:0] DLY_T =
    RW'(term_of(REPEAT_DELAY));
  localparam logic [RW-1:0] PER_T =
    RW'(term_of(REPEAT_PERIOD));

  always_comb begin : cfg_chk
    assert (CFG_OK)
      else $error("debounce_pulse: illegal parameters");
  end

  state_t state_q, state_d;

  logic stab_clr, stab_en, stab_hit;
  logic rep_clr, rep_hit, phase_q;
  logic [RW-1:0] rep_term;
  logic high_region;
  logic level_d, rise_d, fall_d, rep_d;

  tick_counter #(.W(SW)) u_stab (
    .clk   (clk),
    .reset (reset),
    .clr   (stab_clr),
    .en    (stab_en),
    .term  (STAB_T),
    .hit   (stab_hit)
  );

  tick_counter #(.W(RW)) u_rep (
    .clk   (clk),
    .reset (reset),
    .clr   (rep_clr),
    .en    (1'b1),
    .term  (rep_term),
    .hit   (rep_hit)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE_LOW;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE_LOW: begin
        if (dato_sync) state_d = CHECK_HIGH;
      end
      CHECK_HIGH: begin
        if (!dato_sync)    state_d = IDLE_LOW;
        else if (stab_hit) state_d = IDLE_HIGH;
      end
      IDLE_HIGH: begin
        if (!dato_sync) state_d = CHECK_LOW;
      end
      CHECK_LOW: begin
        if (dato_sync)     state_d = IDLE_HIGH;
        else if (stab_hit) state_d = IDLE_LOW;
      end
      default: state_d = IDLE_LOW;
    endcase
  end

  // Stability count is 0 in both idle states, so the
  // first increment on leaving idle yields a count of 1.
  always_comb begin
    stab_clr = (state_d == IDLE_LOW) ||
               (state_d == IDLE_HIGH);
    stab_en  = !stab_clr;

    high_region = (state_q == IDLE_HIGH) ||
                  (state_q == CHECK_LOW);
    rep_term    = phase_q ? PER_T : DLY_T;

    level_d = (state_d == IDLE_HIGH) ||
              (state_d == CHECK_LOW);
    rise_d  = (state_q == CHECK_HIGH) &&
              (state_d == IDLE_HIGH);
    fall_d  = (state_q == CHECK_LOW) &&
              (state_d == IDLE_LOW);
    rep_d   = REP_ON && high_region && rep_hit &&
              (state_d != IDLE_LOW);

    rep_clr = !REP_ON || !high_region ||
              (state_d == IDLE_LOW) || rep_d;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      phase_q <= 1'b0;
    end else if (state_d == IDLE_LOW) begin
      phase_q <= 1'b0;
    end else if (rep_d) begin
      phase_q <= 1'b1;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      level      <= 1'b0;
      rise_pulse <= 1'b0;
      fall_pulse <= 1'b0;
      rep_pulse  <= 1'b0;
    end else begin
      level      <= level_d;
      rise_pulse <= rise_d;
      fall_pulse <= fall_d;
      rep_pulse  <= rep_d;
    end
  end

endmodule
